mem_access_unit: RTL and testbench

// Pipeline-side initiator for the word-wide cache request interface (ADDR/DIN/WE/RREQ/DOUT/RDY).

---
 rtl/mem_access_unit_if.sv | 33 +++
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus bundle for mem_access_unit: pipeline load/store port plus word cache port.
// master = the access unit itself, slave = pipeline and cache side.
interface mem_access_unit_if;
   logic        req;
   logic        store;
   logic [2:0]  funct3;
   logic [31:0] addr_in;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        done;
   logic        busy;
   logic        err;
   logic [31:0] c_addr;
   logic [31:0] c_din;
   logic        c_we;
   logic        c_rreq;
   logic [31:0] c_dout;
   logic        c_rdy;

   modport master (
      input  req, store, funct3, addr_in, wdata,
      output rdata, done, busy, err,
      output c_addr, c_din, c_we, c_rreq,
      input  c_dout, c_rdy
   );

   modport slave (
      output req, store, funct3, addr_in, wdata,
      input  rdata, done, busy, err,
      input  c_addr, c_din, c_we, c_rreq,
      output c_dout, c_rdy
   );
endinterface

// File: rtl/mem_access_unit.sv
// RISC-V load/store to word-cache bridge; sub-word stores via read-modify-write.
// Optional MAU_ALIGN_CHECK_EN: flag misaligned H/W accesses instead of issuing them.
module mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic              i_clk,
   input  logic              i_rst,
   mem_access_unit_if.master io_bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_RESP
   } state_t;

   state_t      r_state;
   logic        r_first;
   logic [31:0] r_wd;
   logic [2:0]  r_f3;
   logic [1:0]  r_lane;
   logic [15:0] r_wdata;
   logic        r_done;
   logic        r_err;
   logic        r_we;
   logic        r_rreq;
   logic [31:0] r_rdata;
   logic [31:0] r_caddr;
   logic [31:0] r_cdin;

   logic        w_bad;
   logic        w_hit;
   logic        w_tout;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ldata;
   logic [31:0] w_merge;

   always_comb begin
      w_bad = 1'b0;
      case (io_bus.funct3)
         3'b000, 3'b001, 3'b010: w_bad = 1'b0;
         3'b100, 3'b101:         w_bad = io_bus.store;
         default:                w_bad = 1'b1;
      endcase
`ifdef MAU_ALIGN_CHECK_EN
      if (io_bus.funct3[1:0] == 2'b01 && io_bus.addr_in[0])
         w_bad = 1'b1;
      if (io_bus.funct3 == 3'b010 && io_bus.addr_in[1:0] != 2'b00)
         w_bad = 1'b1;
`endif
   end

   // the cache may still show ready from its idle state in our first cycle
   assign w_hit  = io_bus.c_rdy && !r_first;
   assign w_tout = (TIMEOUT_CYCLES != 0) &&
                   ((r_wd + 32'd1) >= TIMEOUT_CYCLES);

   assign w_byte = io_bus.c_dout[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? io_bus.c_dout[31:16]
                             : io_bus.c_dout[15:0];

   always_comb begin
      w_ldata = io_bus.c_dout;
      case (r_f3)
         3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ldata = {24'd0, w_byte};
         3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
         3'b101:  w_ldata = {16'd0, w_half};
         default: w_ldata = io_bus.c_dout;
      endcase
   end

   always_comb begin
      w_merge = io_bus.c_dout;
      if (r_f3[1:0] == 2'b00)
         w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
      else if (r_lane[1])
         w_merge[31:16] = r_wdata;
      else
         w_merge[15:0] = r_wdata;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_first <= 1'b0;
         r_wd    <= '0;
         r_f3    <= '0;
         r_lane  <= '0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_rreq  <= 1'b0;
         r_rdata <= '0;
         r_caddr <= '0;
         r_cdin  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.req && !r_done) begin
                  r_f3    <= io_bus.funct3;
                  r_lane  <= io_bus.addr_in[1:0];
                  r_wdata <= io_bus.wdata[15:0];
                  r_caddr <= {io_bus.addr_in[31:2], 2'b00};
                  r_first <= 1'b1;
                  r_wd    <= '0;
                  if (w_bad) begin
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                     r_state <= S_RESP;
                  end else if (!io_bus.store) begin
                     r_rreq  <= 1'b1;
                     r_state <= S_RD;
                  end else if (io_bus.funct3 == 3'b010) begin
                     r_we    <= 1'b1;
                     r_cdin  <= io_bus.wdata;
                     r_state <= S_WR;
                  end else begin
                     r_rreq  <= 1'b1;
                     r_state <= S_RMW_RD;
                  end
               end
            end
            S_RESP: begin
               r_done  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_first <= 1'b0;
               r_wd    <= r_wd + 32'd1;
               if (w_hit) begin
                  case (r_state)
                     S_RD: begin
                        r_rdata <= w_ldata;
                        r_rreq  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                     end
                     S_RMW_RD: begin
                        r_cdin  <= w_merge;
                        r_rreq  <= 1'b0;
                        r_we    <= 1'b1;
                        r_first <= 1'b1;
                        r_wd    <= '0;
                        r_state <= S_RMW_WR;
                     end
                     default: begin
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_RESP;
                     end
                  endcase
               end else if (w_tout) begin
                  r_rreq  <= 1'b0;
                  r_we    <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= S_RESP;
               end
            end
         endcase
      end
   end

   assign io_bus.rdata  = r_rdata;
   assign io_bus.done   = r_done;
   assign io_bus.err    = r_err;
   assign io_bus.busy   = io_bus.req & ~r_done;
   assign io_bus.c_addr = r_caddr;
   assign io_bus.c_din  = r_cdin;
   assign io_bus.c_we   = r_we;
   assign io_bus.c_rreq = r_rreq;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: cache responder, operation-level model,
// and a per-cycle compare process against the model.
module tb_mem_access_unit;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   mem_access_unit_if bus();

   mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   int vecs  = 0;
   int fails = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // cache responder: completes in the lat-th cycle a request is held
   logic [31:0] cmem [int unsigned];
   int lat      = 3;
   bit stall    = 0;
   bit idle_rdy = 0;
   int cnt      = 0;
   logic pr = 1'b0, pw = 1'b0;
   int n_rd = 0, n_wr = 0;

   always @(negedge clk) begin
      if (bus.c_rreq || bus.c_we) begin
         if (bus.c_rreq !== pr || bus.c_we !== pw) begin
            cnt = 1;
            if (bus.c_rreq) n_rd++;
            else n_wr++;
         end else begin
            cnt++;
         end
         if (!stall && cnt == lat) begin
            bus.c_rdy = 1'b1;
            if (bus.c_rreq) bus.c_dout = cmem[bus.c_addr];
            else begin
               cmem[bus.c_addr] = bus.c_din;
               bus.c_dout = $urandom;
            end
         end else begin
            bus.c_rdy  = idle_rdy && cnt == 1;
            bus.c_dout = $urandom;
         end
      end else begin
         cnt = 0;
         bus.c_rdy  = idle_rdy;
         bus.c_dout = $urandom;
      end
      pr = bus.c_rreq;
      pw = bus.c_we;
   end

   // operation-level model
   logic [31:0] ref_mem [int unsigned];
   bit          armed = 0;
   bit          pending = 0;
   bit          got_done = 0;
   logic        e_err = 1'b0;
   logic [31:0] e_rdata = '0;
   logic [31:0] prev_rdata = '0;
   logic [31:0] d_rdata = '0;
   int          e_lat = 0;
   int          t0 = 0;

   function automatic logic [31:0] load_val(logic [31:0] w, logic [2:0] f3,
                                            logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (int'(a) * 8));
      h = 16'(w >> (int'(a[1]) * 16));
      case (f3)
         3'b000:  return 32'($signed(b));
         3'b100:  return 32'(b);
         3'b001:  return 32'($signed(h));
         3'b101:  return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_val(logic [31:0] w, logic [2:0] f3,
                                             logic [1:0] a, logic [31:0] d);
      logic [31:0] m;
      int sh;
      if (f3 == 3'b010) return d;
      if (f3 == 3'b000) begin
         sh = int'(a) * 8;
         m  = 32'hFF << sh;
      end else begin
         sh = int'(a[1]) * 16;
         m  = 32'hFFFF << sh;
      end
      return (w & ~m) | ((d << sh) & m);
   endfunction

   always @(negedge clk) begin
      if (!rst && armed) begin
         chk("busy", 32'(bus.busy), 32'(bus.req & ~bus.done));
         chk("rdata_hold", bus.rdata,
             (pending && !bus.done) ? prev_rdata : e_rdata);
         if (bus.done) begin
            if (!pending) begin
               vecs++;
               fails++;
               $display("FAIL spurious_done: got 1 expected 0 (t=%0t)", $time);
            end else begin
               chk("err", 32'(bus.err), 32'(e_err));
               chk("latency", 32'(cyc - t0), 32'(e_lat));
               d_rdata  = bus.rdata;
               pending  = 0;
               got_done = 1;
            end
         end else begin
            chk("err_idle", 32'(bus.err), 32'd0);
         end
      end
   end

   task automatic op(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                     bit use_lit, logic [31:0] lit);
      logic [31:0] wa;
      bit bad;
      int nr, nw;
      @(posedge clk);
      #2;
      wa  = {a[31:2], 2'b00};
      bad = !(f3 inside {3'b000, 3'b001, 3'b010}) &&
            !(!st && f3 inside {3'b100, 3'b101});
`ifdef MAU_ALIGN_CHECK_EN
      if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) bad = 1;
      if (f3 == 3'b010 && a[1:0] != 2'b00) bad = 1;
`endif
      prev_rdata = e_rdata;
      nr = (st && f3 == 3'b010) ? 0 : 1;
      nw = st ? 1 : 0;
      if (bad) begin
         e_err = 1'b1;
         e_lat = 1;
         nr = 0;
         nw = 0;
      end else if (stall) begin
         e_err = 1'b1;
         e_lat = TMO + 1;
         nw = (st && f3 == 3'b010) ? 1 : 0;
      end else begin
         e_err = 1'b0;
         if (!st) begin
            e_rdata = load_val(ref_mem[wa], f3, a[1:0]);
            e_lat = lat + 1;
         end else begin
            ref_mem[wa] = store_val(ref_mem[wa], f3, a[1:0], wd);
            e_lat = (f3 == 3'b010) ? lat + 1 : 2 * lat + 1;
         end
      end
      n_rd = 0;
      n_wr = 0;
      got_done = 0;
      t0 = cyc;
      pending = 1;
      bus.req = 1'b1;
      bus.store = st;
      bus.funct3 = f3;
      bus.addr_in = a;
      bus.wdata = wd;
      for (int i = 0; i < 100 && !got_done; i++) begin
         @(posedge clk);
         #2;
      end
      if (!got_done) begin
         vecs++;
         fails++;
         $display("FAIL done_wait: got none expected DONE within 100 cycles");
         pending = 0;
      end
      bus.req = 1'b0;
      chk("n_reads", 32'(n_rd), 32'(nr));
      chk("n_writes", 32'(n_wr), 32'(nw));
      if (st && !bad && !stall) chk("mem", cmem[wa], ref_mem[wa]);
      if (use_lit) chk("literal", st ? cmem[wa] : d_rdata, lit);
   endtask

   task automatic rst_mid_rmw();
      @(posedge clk);
      #2;
      bus.req = 1'b1;
      bus.store = 1'b1;
      bus.funct3 = 3'b000;
      bus.addr_in = 32'h300;
      bus.wdata = 32'h11;
      for (int i = 0; i < 50 && !bus.c_we; i++) @(negedge clk);
      chk("rmw_wr_seen", 32'(bus.c_we), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_we", 32'(bus.c_we), 32'd0);
      chk("rst_rreq", 32'(bus.c_rreq), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      bus.req = 1'b0;
      e_rdata = '0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_mem", cmem[32'h300], ref_mem[32'h300]);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      bus.req = 1'b0;
      bus.store = 1'b0;
      bus.funct3 = 3'b000;
      bus.addr_in = '0;
      bus.wdata = '0;
      cmem[32'h100] = 32'h8081_7F80;
      cmem[32'h200] = 32'h1122_3344;
      cmem[32'h300] = 32'h0;
      ref_mem[32'h100] = 32'h8081_7F80;
      ref_mem[32'h200] = 32'h1122_3344;
      ref_mem[32'h300] = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_c_we", 32'(bus.c_we), 32'd0);
      chk("rst_c_rreq", 32'(bus.c_rreq), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_c_addr", bus.c_addr, 32'd0);
      chk("rst_c_din", bus.c_din, 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      armed = 1;

      op(0, 3'b000, 32'h100, 0, 1, 32'hFFFF_FF80);
      op(0, 3'b100, 32'h101, 0, 1, 32'h0000_007F);
      op(0, 3'b001, 32'h102, 0, 1, 32'hFFFF_8081);
      op(0, 3'b101, 32'h102, 0, 1, 32'h0000_8081);
      op(0, 3'b000, 32'h103, 0, 1, 32'hFFFF_FF80);
      op(0, 3'b100, 32'h102, 0, 1, 32'h0000_0081);
      op(0, 3'b010, 32'h100, 0, 1, 32'h8081_7F80);
      chk("lw_latency", 32'(cyc - t0 - 1), 32'd4);

      op(1, 3'b000, 32'h201, 32'hFFFF_FFAB, 1, 32'h1122_AB44);
      cmem[32'h200] = 32'h1122_3344;
      ref_mem[32'h200] = 32'h1122_3344;
      op(1, 3'b001, 32'h202, 32'h1234_BEEF, 1, 32'hBEEF_3344);
      op(1, 3'b010, 32'h200, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF);

      op(0, 3'b011, 32'h100, 0, 0, 0);
      op(1, 3'b100, 32'h100, 32'h55, 0, 0);
      op(0, 3'b110, 32'h100, 0, 0, 0);
      op(1, 3'b101, 32'h200, 32'h55, 0, 0);

`ifdef MAU_ALIGN_CHECK_EN
      op(0, 3'b010, 32'h103, 0, 0, 0);
      op(0, 3'b001, 32'h101, 0, 0, 0);
`else
      op(0, 3'b010, 32'h103, 0, 1, 32'h8081_7F80);
      op(0, 3'b001, 32'h101, 0, 1, 32'h0000_7F80);
`endif

      idle_rdy = 1;
      lat = 2;
      op(0, 3'b010, 32'h200, 0, 1, 32'hDEAD_BEEF);
      op(1, 3'b000, 32'h302, 32'h5A, 1, 32'h005A_0000);
      idle_rdy = 0;
      lat = 3;

      stall = 1;
      op(0, 3'b010, 32'h100, 0, 0, 0);
      op(1, 3'b000, 32'h201, 32'h77, 0, 0);
      stall = 0;
      op(0, 3'b010, 32'h200, 0, 1, 32'hDEAD_BEEF);

      rst_mid_rmw();
      op(0, 3'b001, 32'h200, 0, 1, 32'hFFFF_BEEF);

      repeat (3) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
